// File: rtl/bram_shift_harness.sv
// bram_shift_harness: serial test harness around a fuzzed primitive.
// A serial bit stream is shifted into a DIN_N-bit word. A frame strobe
// applies the word to the DUT, samples the DUT response CAPTURE_DELAY
// cycles later and streams it back out MSB first.
//
// Ports:
//   clk_i        single clock, rising edge
//   rst_i        asynchronous reset, active high
//   di_i         serial data in, shifted into the LSB
//   stb_i        frame strobe: apply shifted word, start capture
//   do_o         serial data out (MSB of the output shift register)
//   busy_o       high while a frame is being captured or read out
//   frame_err_o  sticky flag for bad frame length or strobe while busy
//   dut_din_o    registered parallel word driven to the DUT
//   dut_dout_i   parallel word returned by the DUT
module bram_shift_harness #(
   parameter int unsigned DIN_N         = 8,
   parameter int unsigned DOUT_N        = 8,
   parameter int unsigned CAPTURE_DELAY = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              di_i,
   input  logic              stb_i,
   output logic              do_o,
   output logic              busy_o,
   output logic              frame_err_o,
   output logic [DIN_N-1:0]  dut_din_o,
   input  logic [DOUT_N-1:0] dut_dout_i
);

   // bit_cnt must hold DIN_N+1 so an over-long frame stays distinguishable.
   localparam int unsigned BIT_CNT_W = $clog2(DIN_N + 2);
   localparam int unsigned DLY_W     = 4;
   localparam int unsigned OUT_CNT_W = (DOUT_N > 1) ? $clog2(DOUT_N) : 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_SHIFT_OUT
   } state_e;

   state_e                 state_q, state_d;
   logic [DIN_N-1:0]       din_shr_q, din_shr_d;
   logic [DIN_N-1:0]       dut_din_q, dut_din_d;
   logic [DOUT_N-1:0]      dout_shr_q, dout_shr_d;
   logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [DLY_W-1:0]       dly_cnt_q, dly_cnt_d;
   logic [OUT_CNT_W-1:0]   out_cnt_q, out_cnt_d;
   logic                   busy_q, busy_d;
   logic                   frame_err_q, frame_err_d;
   logic                   accept_c;

   // A strobe is taken only in IDLE with exactly DIN_N bits since the last strobe.
   assign accept_c = stb_i && (state_q == ST_IDLE)
                     && (bit_cnt_q == BIT_CNT_W'(DIN_N));

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:      if (accept_c) state_d = ST_WAIT;
         ST_WAIT:      if (dly_cnt_q == '0) state_d = ST_SHIFT_OUT;
         ST_SHIFT_OUT: if (out_cnt_q == '0) state_d = ST_IDLE;
         default:      state_d = ST_IDLE;
      endcase
   end

   // Datapath / output next-state logic
   always_comb begin
      din_shr_d   = din_shr_q;
      bit_cnt_d   = bit_cnt_q;
      dut_din_d   = dut_din_q;
      dly_cnt_d   = dly_cnt_q;
      dout_shr_d  = dout_shr_q;
      out_cnt_d   = out_cnt_q;
      busy_d      = busy_q;
      frame_err_d = frame_err_q;

      // Shift-in runs in every state; a strobe cycle holds data and restarts the count.
      // The shift-and-or form keeps DIN_N == 1 free of out-of-range slices.
      if (stb_i) begin
         bit_cnt_d = '0;
      end else begin
         din_shr_d = (din_shr_q << 1) | DIN_N'(di_i);
         if (bit_cnt_q != BIT_CNT_W'(DIN_N + 1)) begin
            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
         end
      end

      if (stb_i && !accept_c) begin
         frame_err_d = 1'b1;
      end

      case (state_q)
         ST_IDLE: begin
            if (accept_c) begin
               dut_din_d = din_shr_q;
               dly_cnt_d = DLY_W'(CAPTURE_DELAY - 1);
               busy_d    = 1'b1;
            end
         end
         ST_WAIT: begin
            if (dly_cnt_q == '0) begin
               dout_shr_d = dut_dout_i;
               out_cnt_d  = OUT_CNT_W'(DOUT_N - 1);
            end else begin
               dly_cnt_d = dly_cnt_q - DLY_W'(1);
            end
         end
         ST_SHIFT_OUT: begin
            // Zero-fill so do_o returns to 0 once the word has been read out.
            dout_shr_d = dout_shr_q << 1;
            if (out_cnt_q == '0) begin
               busy_d = 1'b0;
            end else begin
               out_cnt_d = out_cnt_q - OUT_CNT_W'(1);
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         din_shr_q   <= '0;
         bit_cnt_q   <= '0;
         dut_din_q   <= '0;
         dly_cnt_q   <= '0;
         dout_shr_q  <= '0;
         out_cnt_q   <= '0;
         busy_q      <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         din_shr_q   <= din_shr_d;
         bit_cnt_q   <= bit_cnt_d;
         dut_din_q   <= dut_din_d;
         dly_cnt_q   <= dly_cnt_d;
         dout_shr_q  <= dout_shr_d;
         out_cnt_q   <= out_cnt_d;
         busy_q      <= busy_d;
         frame_err_q <= frame_err_d;
      end
   end

   assign do_o        = dout_shr_q[DOUT_N-1];
   assign busy_o      = busy_q;
   assign frame_err_o = frame_err_q;
   assign dut_din_o   = dut_din_q;

endmodule

// File: tb/tb_bram_shift_harness.sv
// tb_bram_shift_harness: directed bench for bram_shift_harness.
// Four instances with different parameters share di/stb/rst; sel picks the
// instance under test (strobe and reset are gated to it, outputs are muxed).
//   A: defaults, loopback
//   B: CAPTURE_DELAY=3, DUT = inverted word with two register stages
//   C: DIN_N=16, DOUT_N=4, DUT = dut_din[15:12]
//   D: DIN_N=8, DOUT_N=5, CAPTURE_DELAY=3, DUT = dut_din[4:0]
//      (DOUT_N+CAPTURE_DELAY == DIN_N lets a pipelined frame hit the first IDLE cycle)
module tb_bram_shift_harness;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst = 1'b0;
   logic di  = 1'b0;
   logic stb = 1'b0;
   int   sel = 0;

   int n_chk  = 0;
   int n_pass = 0;

   logic rst_a, rst_b, rst_c, rst_d;
   logic stb_a, stb_b, stb_c, stb_d;
   assign rst_a = rst && (sel == 0);
   assign rst_b = rst && (sel == 1);
   assign rst_c = rst && (sel == 2);
   assign rst_d = rst && (sel == 3);
   assign stb_a = stb && (sel == 0);
   assign stb_b = stb && (sel == 1);
   assign stb_c = stb && (sel == 2);
   assign stb_d = stb && (sel == 3);

   logic        do_a, do_b, do_c, do_d;
   logic        busy_a, busy_b, busy_c, busy_d;
   logic        ferr_a, ferr_b, ferr_c, ferr_d;
   logic [7:0]  din_a, din_b, din_d;
   logic [15:0] din_c;
   logic [7:0]  dout_b;
   logic [7:0]  p1_b = '0;
   logic [7:0]  p2_b = '0;

   // Instance B's DUT: inverted word with two cycles of register latency.
   always @(posedge clk) begin
      p1_b <= ~din_b;
      p2_b <= p1_b;
   end
   assign dout_b = p2_b;

   bram_shift_harness u_a (
      .clk_i(clk), .rst_i(rst_a), .di_i(di), .stb_i(stb_a),
      .do_o(do_a), .busy_o(busy_a), .frame_err_o(ferr_a),
      .dut_din_o(din_a), .dut_dout_i(din_a)
   );

   bram_shift_harness #(.CAPTURE_DELAY(3)) u_b (
      .clk_i(clk), .rst_i(rst_b), .di_i(di), .stb_i(stb_b),
      .do_o(do_b), .busy_o(busy_b), .frame_err_o(ferr_b),
      .dut_din_o(din_b), .dut_dout_i(dout_b)
   );

   bram_shift_harness #(.DIN_N(16), .DOUT_N(4)) u_c (
      .clk_i(clk), .rst_i(rst_c), .di_i(di), .stb_i(stb_c),
      .do_o(do_c), .busy_o(busy_c), .frame_err_o(ferr_c),
      .dut_din_o(din_c), .dut_dout_i(din_c[15:12])
   );

   bram_shift_harness #(.DIN_N(8), .DOUT_N(5), .CAPTURE_DELAY(3)) u_d (
      .clk_i(clk), .rst_i(rst_d), .di_i(di), .stb_i(stb_d),
      .do_o(do_d), .busy_o(busy_d), .frame_err_o(ferr_d),
      .dut_din_o(din_d), .dut_dout_i(din_d[4:0])
   );

   logic        do_s, busy_s, ferr_s;
   logic [31:0] din_s;
   always_comb begin
      do_s = do_a; busy_s = busy_a; ferr_s = ferr_a; din_s = 32'(din_a);
      case (sel)
         1: begin do_s = do_b; busy_s = busy_b; ferr_s = ferr_b; din_s = 32'(din_b); end
         2: begin do_s = do_c; busy_s = busy_c; ferr_s = ferr_c; din_s = 32'(din_c); end
         3: begin do_s = do_d; busy_s = busy_d; ferr_s = ferr_d; din_s = 32'(din_d); end
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reset the selected instance and leave rst low so shifting can start next edge.
   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      chk("rst_do", 32'(do_s), 32'd0);
      chk("rst_busy", 32'(busy_s), 32'd0);
      chk("rst_ferr", 32'(ferr_s), 32'd0);
      chk("rst_din", din_s, 32'd0);
      rst = 1'b0;
   endtask

   task automatic shift(input logic [31:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         di = v[i];
         tick();
      end
      di = 1'b0;
   endtask

   task automatic strobe();
      stb = 1'b1;
      tick();
      stb = 1'b0;
   endtask

   // Check n serial bits MSB first, optionally pulsing stb before bit stb_at's edge.
   task automatic readout(input logic [31:0] v, input int n, input int stb_at);
      for (int i = n - 1; i >= 0; i--) begin
         chk("do_bit", 32'(do_s), 32'(v[i]));
         chk("busy_rd", 32'(busy_s), 32'd1);
         stb = (i == stb_at);
         tick();
      end
      stb = 1'b0;
      chk("busy_end", 32'(busy_s), 32'd0);
      chk("do_idle", 32'(do_s), 32'd0);
   endtask

   logic [31:0] nxt;

   initial begin
      // 1: loopback, 8'hA5
      sel = 0;
      do_reset();
      shift(32'hA5, 8);
      strobe();
      chk("t1_din", din_s, 32'hA5);
      chk("t1_busy", 32'(busy_s), 32'd1);
      chk("t1_do_wait", 32'(do_s), 32'd0);
      tick();
      readout(32'hA5, 8, -1);
      chk("t1_ferr", 32'(ferr_s), 32'd0);

      // 2: short frames rejected, then a good frame still accepted
      shift(32'h55, 7);
      strobe();
      chk("t2_ferr", 32'(ferr_s), 32'd1);
      chk("t2_din", din_s, 32'hA5);
      chk("t2_busy", 32'(busy_s), 32'd0);
      shift(32'h2A, 7);
      strobe();
      chk("t2_ferr2", 32'(ferr_s), 32'd1);
      chk("t2_din2", din_s, 32'hA5);
      chk("t2_busy2", 32'(busy_s), 32'd0);
      shift(32'h5A, 8);
      strobe();
      chk("t2_acc_din", din_s, 32'h5A);
      chk("t2_acc_busy", 32'(busy_s), 32'd1);
      chk("t2_sticky", 32'(ferr_s), 32'd1);
      tick();
      readout(32'h5A, 8, -1);

      // 5: stb while busy flags an error but leaves the readout intact
      do_reset();
      shift(32'h96, 8);
      strobe();
      tick();
      readout(32'h96, 8, 6);
      chk("t5_ferr", 32'(ferr_s), 32'd1);
      chk("t5_din", din_s, 32'h96);

      // 3: capture delay 3, inverted response
      sel = 1;
      do_reset();
      shift(32'h0F, 8);
      strobe();
      chk("t3_din", din_s, 32'h0F);
      chk("t3_busy", 32'(busy_s), 32'd1);
      tick();
      chk("t3_do_w1", 32'(do_s), 32'd0);
      chk("t3_busy_w1", 32'(busy_s), 32'd1);
      tick();
      chk("t3_do_w2", 32'(do_s), 32'd0);
      tick();
      readout(32'hF0, 8, -1);
      chk("t3_ferr", 32'(ferr_s), 32'd0);

      // 4: next frame shifted during readout, strobed on first IDLE cycle
      sel = 3;
      do_reset();
      shift(32'hA5, 8);
      strobe();
      nxt = 32'h3C;
      for (int k = 0; k < 8; k++) begin
         di = nxt[7-k];
         tick();
         if (k < 2) begin
            chk("t4_do_wait", 32'(do_s), 32'd0);
            chk("t4_busy_wait", 32'(busy_s), 32'd1);
         end else if (k < 7) begin
            chk("t4_do_bit", 32'(do_s), 32'((5'b00101 >> (6 - k)) & 5'd1));
         end else begin
            chk("t4_idle", 32'(busy_s), 32'd0);
         end
      end
      di = 1'b0;
      strobe();
      chk("t4_din", din_s, 32'h3C);
      chk("t4_ferr", 32'(ferr_s), 32'd0);
      chk("t4_busy", 32'(busy_s), 32'd1);
      tick();
      tick();
      tick();
      readout(32'h1C, 5, -1);

      // 6: 16-in / 4-out, async reset mid-readout
      sel = 2;
      do_reset();
      shift(32'hBEEF, 16);
      strobe();
      chk("t6_din", din_s, 32'hBEEF);
      chk("t6_busy", 32'(busy_s), 32'd1);
      tick();
      chk("t6_bit3", 32'(do_s), 32'd1);
      stb = 1'b1;
      tick();
      stb = 1'b0;
      chk("t6_bit2", 32'(do_s), 32'd0);
      chk("t6_ferr", 32'(ferr_s), 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("t6_rst_do", 32'(do_s), 32'd0);
      chk("t6_rst_busy", 32'(busy_s), 32'd0);
      chk("t6_rst_ferr", 32'(ferr_s), 32'd0);
      chk("t6_rst_din", din_s, 32'd0);
      tick();
      rst = 1'b0;
      tick();
      chk("t6_post_busy", 32'(busy_s), 32'd0);
      chk("t6_post_do", 32'(do_s), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bram_shift_harness.md
Name: bram_shift_harness

Overview:
- Parametrised serial test harness wrapping a fuzzed primitive (BRAM or similar) behind three pins: clk, serial in, serial out.
- Successor to the fixed 8-in/8-out shift wrapper, with:
  - configurable in/out widths;
  - a configurable capture delay;
  - frame-length checking with a sticky error flag;
  - a busy handshake;
  - shift-in that continues while the previous frame is being read out.
- Sits at the top of a minitest design; the DUT ports connect to `dut_din` and `dut_dout`.

Parameters:
- DIN_N, 8, width of the parallel word driven to the DUT (1..256).
- DOUT_N, 8, width of the parallel word captured from the DUT (1..256).
- CAPTURE_DELAY, 1, cycles from `dut_din` update to `dut_dout` sampling (1..15).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  asynchronous reset, active-high.
- di  input  1  serial data in, shifted into the LSB each cycle.
- stb  input  1  frame strobe: apply the shifted word and start capture.
- do  output  1  serial data out = `dout_shr[DOUT_N-1]`.
- busy  output  1  high from the cycle after an accepted stb until the last output bit.
- frame_err  output  1  sticky error flag, cleared only by rst.
- dut_din  output  DIN_N  registered parallel word to the DUT.
- dut_dout  input  DOUT_N  parallel word from the DUT.

Behaviour:
- Reset (async on rst=1): the following clear to 0 and state goes to IDLE:
  - registers: din_shr, dut_din, dout_shr, bit_cnt, dly_cnt, out_cnt;
  - outputs: do, busy, frame_err.
- Shift-in runs in every state:
  - `din_shr <= {din_shr[DIN_N-2:0], di}`;
  - bit_cnt increments, saturating at DIN_N+1.
  - On a cycle with stb=1, di is NOT shifted and bit_cnt is cleared to 0.
- States: IDLE, WAIT, SHIFT_OUT.
- IDLE, stb=1 with bit_cnt==DIN_N (accepted):
  - `dut_din <= din_shr`;
  - `dly_cnt <= CAPTURE_DELAY-1`;
  - busy<=1;
  - go to WAIT.
- IDLE, stb=1 with bit_cnt!=DIN_N (rejected):
  - frame_err<=1;
  - dut_din unchanged;
  - stay in IDLE.
- WAIT:
  - If dly_cnt==0: `dout_shr <= dut_dout`, `out_cnt <= DOUT_N-1`, go to SHIFT_OUT.
  - Else dly_cnt decrements.
- SHIFT_OUT:
  - Each cycle: `dout_shr <= {dout_shr[DOUT_N-2:0], 1'b0}`.
  - If out_cnt==0: busy<=0, go to IDLE. Else out_cnt decrements.
- Timing for an accepted stb sampled at edge T:
  - dut_din valid in cycle T+1;
  - dut_dout sampled at edge T+CAPTURE_DELAY;
  - do carries bits DOUT_N-1 .. 0 (MSB first) in cycles T+CAPTURE_DELAY+1 .. T+CAPTURE_DELAY+DOUT_N;
  - busy high over the same window as the WAIT and SHIFT_OUT states;
  - IDLE again after the last bit.
- do is 0 outside SHIFT_OUT, since zero-fill leaves dout_shr=0 after readout.
- stb while busy: ignored for data (dut_din and state unchanged), sets frame_err, and clears bit_cnt.
- Back-to-back frames: the next frame may be shifted in during WAIT/SHIFT_OUT. A stb in the first IDLE cycle with bit_cnt==DIN_N is accepted.
- DIN_N=1 or DOUT_N=1: the shift registers reduce to a single flop. Same rules apply, with no out-of-range slicing.
- rst asserted mid-frame aborts immediately to the reset state. The first cycle after deassert starts a fresh bit_cnt=0.

Test Plan:
1. Defaults, DUT loopback (`dut_dout = dut_din`): shift 8'hA5 MSB first, then stb -> dut_din=8'hA5 one cycle later; do serial = 1,0,1,0,0,1,0,1 in cycles T+2..T+9; busy high T+1..T+9; frame_err=0.
2. Defaults: shift 7 bits, then stb -> frame_err=1 and stays 1; dut_din keeps its prior value; busy stays 0; a following correct 8-bit frame is still accepted.
3. CAPTURE_DELAY=3, dut_dout = registered `~dut_din` with 2-cycle latency: shift 8'h0F, stb -> do serial = 8'hF0 starting at T+4.
4. Pipelined: shift frame 8'h3C during readout of the prior frame, stb on the first IDLE cycle -> accepted, dut_din=8'h3C, no frame_err.
5. stb pulsed during busy -> frame_err=1; in-flight readout completes unchanged.
6. DIN_N=16, DOUT_N=4: shift 16'hBEEF, stb -> dut_din=16'hBEEF; do emits `dut_dout[3:0]` over 4 cycles. Assert rst mid-readout -> do=0, busy=0, frame_err=0 the same cycle.
